// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic RV32I field bundles and writes them
// sequentially into instruction memory over a valid/ready stream.
module instr_encoder_loader #(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cls,
    input  logic [2:0]        funct3,
    input  logic              funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [20:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FULL} state_t;
    state_t state;
    logic [ADDR_W-1:0] ptr;
    logic [6:0] f7;
    logic [11:0] i12;
    logic [31:0] enc;
    logic illegal, accept;

    assign full     = count == DEPTH_C;
    assign busy     = state == S_LOAD;
    assign in_ready = busy && !full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        f7 = funct7 ? 7'b0100000 : 7'b0000000;
        // shift-immediate forms carry the funct7 pattern in imm[11:5]
        i12 = (funct3 == 3'b001 || funct3 == 3'b101) ? {f7, imm[4:0]} : imm[11:0];
        illegal = cls[2:1] == 2'b11
                || (cls == 3'b100 && funct3[2:1] == 2'b01)
                || (cls == 3'b001 && funct3 == 3'b001 && funct7)
                || (cls == 3'b011 && funct7 && funct3 != 3'b000 && funct3 != 3'b101);
        case (cls)
            3'b000:  enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            3'b001:  enc = {i12, rs1, funct3, rd, 7'b0010011};
            3'b010:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            3'b011:  enc = {f7, rs2, rs1, funct3, rd, 7'b0110011};
            3'b100:  enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            3'b101:  enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default: enc = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= BASE_C;
            count      <= '0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_C;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state     <= S_LOAD;
                ptr       <= BASE_C;
                count     <= '0;
                err       <= 1'b0;
                imem_addr <= BASE_C;
            end else begin
                if (accept && illegal)
                    err <= 1'b1;
                if (accept && !illegal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc;
                    ptr        <= ptr + 1'b1;
                    count      <= count + 1'b1;
                end
                if (accept && !illegal && count == DEPTH_C - 1'b1)
                    state <= S_FULL;
                else if (busy && finish)
                    state <= S_DONE;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized and directed checks of the loader
// against a field-level encoding model and a simple session model.
module tb_instr_encoder_loader;
    localparam int DEPTH = 12, ADDR_W = 4, BASE = 2;

    logic clk = 0, rst = 1, start = 0, finish = 0, in_valid = 0, funct7 = 0;
    logic [2:0] cls = 0, funct3 = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [20:0] imm = 0;
    logic in_ready, imem_we, busy, full, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [ADDR_W:0] count;

    int tests = 0, fails = 0;
    bit m_load, m_err, exp_we;
    int m_cnt;
    int unsigned m_addr, m_data;
    int unsigned hexq[$];

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(in_ready), .cls(cls), .funct3(funct3), .funct7(funct7), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .busy(busy), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ill(input int c, input int f3, input bit f7);
        return c > 5 || (c == 4 && (f3 == 2 || f3 == 3)) || (c == 1 && f3 == 1 && f7)
            || (c == 3 && f7 && f3 != 0 && f3 != 5);
    endfunction

    function automatic int unsigned enc(input int c, input int f3, input bit f7,
                                        input int d, input int s1, input int s2, input int unsigned u);
        int unsigned hi7, regs;
        hi7  = f7 ? 32'h20 : 32'h0;
        regs = (s1 << 15) | (f3 << 12);
        case (c)
            0: return ((u & 'hfff) << 20) | regs | (d << 7) | 'h03;
            1: return ((((f3 == 1 || f3 == 5) ? ((hi7 << 5) | (u & 31)) : (u & 'hfff))) << 20)
                      | regs | (d << 7) | 'h13;
            2: return (((u >> 5) & 127) << 25) | (s2 << 20) | regs | ((u & 31) << 7) | 'h23;
            3: return (hi7 << 25) | (s2 << 20) | regs | (d << 7) | 'h33;
            4: return (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (s2 << 20) | regs
                      | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 'h63;
            5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
                      | (((u >> 12) & 255) << 12) | (d << 7) | 'h6f;
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("we", imem_we, exp_we);
        chk("addr", imem_addr, m_addr);
        chk("wdata", imem_wdata, m_data);
        chk("count", count, m_cnt);
        chk("full", full, m_cnt == DEPTH);
        chk("busy", busy, m_load);
        chk("err", err, m_err);
        chk("ready", in_ready, m_load && m_cnt < DEPTH);
        if (exp_we && hexq.size() > 0) chk("spec_hex", imem_wdata, hexq.pop_front());
    endtask

    task automatic cycle(input bit st, input bit fin, input bit v, input int c, input int f3,
                         input bit f7, input int d, input int s1, input int s2, input int im,
                         input int unsigned hx);
        bit rdy;
        @(negedge clk);
        check_outputs();
        start = st; finish = fin; in_valid = v; cls = 3'(c); funct3 = 3'(f3); funct7 = f7;
        rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 21'(im);
        #1;
        rdy = m_load && m_cnt < DEPTH;
        exp_we = 0;
        if (st) begin
            m_load = 1; m_cnt = 0; m_err = 0; m_addr = BASE;
        end else begin
            if (rdy && v) begin
                if (ill(c, f3, f7)) m_err = 1;
                else begin
                    exp_we = 1;
                    m_addr = BASE + m_cnt;
                    m_data = enc(c, f3, f7, d, s1, s2, im & 'h1fffff);
                    if (hx != 0) hexq.push_back(hx);
                    m_cnt++;
                    if (m_cnt == DEPTH) m_load = 0;
                end
            end
            if (fin) m_load = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1;
        #1 chk("rst_we", imem_we, 0);
        start = 0; finish = 0; in_valid = 0;
        m_load = 0; m_err = 0; m_cnt = 0; m_addr = BASE; m_data = 0; exp_we = 0;
        hexq.delete();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic rnd_cycle(input int pst, input int pfin);
        cycle($urandom % pst == 0, $urandom % pfin == 0, $urandom % 4 != 0, $urandom % 8,
              $urandom % 8, 1'($urandom), $urandom % 32, $urandom % 32, $urandom % 32,
              int'($urandom), 0);
    endtask

    initial begin
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 0, 0, 3, 1, 2, 0, 'h002081B3);
        cycle(0, 0, 1, 3, 0, 1, 3, 1, 2, 0, 'h402081B3);
        cycle(0, 0, 1, 1, 0, 0, 5, 0, 0, -1, 'hFFF00293);
        cycle(0, 0, 1, 2, 2, 0, 0, 1, 2, 4, 'h0020A223);
        cycle(0, 0, 1, 4, 0, 0, 0, 1, 2, 8, 'h00208463);
        cycle(0, 0, 1, 5, 0, 0, 1, 0, 0, 16, 'h010000EF);
        cycle(0, 0, 1, 6, 0, 0, 1, 1, 1, 0, 0);
        cycle(0, 0, 1, 1, 5, 1, 4, 4, 0, 3, 'h40325213);
        cycle(0, 0, 1, 3, 2, 1, 1, 1, 1, 0, 0);
        cycle(0, 0, 1, 4, 1, 0, 0, 5, 6, -4, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 2, 0, 7, 3, 0, -8, 0);
        cycle(0, 0, 1, 0, 2, 0, 7, 3, 0, 12, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 4; i++)
            cycle(0, 0, 1, $urandom % 6, 0, 0, $urandom % 32, $urandom % 32, $urandom % 32,
                  int'($urandom), 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 1, 1, 0, 5, 0);
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom % 250 == 0) do_reset();
            rnd_cycle(i < 400 ? 30 : 60, 25);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
